// File: rtl/led_effect_pkg.sv
// led_effect_pkg
//   Shared definitions for the LED pattern engine: the mode select width,
//   the four pattern mode codes and the bounce direction type.
package led_effect_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_BOUNCE = 2'd0;
  localparam mode_t MODE_CHASE  = 2'd1;
  localparam mode_t MODE_FILL   = 2'd2;
  localparam mode_t MODE_BLINK  = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
//   Step prescaler. Counts 0..DIV-1 and raises tick while the count sits at
//   DIV-1, so one tick is produced every DIV clocks. clr forces the count back
//   to 0 and takes priority over wrapping.
// Ports:
//   clk_50M  in   system clock
//   rst      in   asynchronous active-high reset
//   clr      in   synchronous clear of the count
//   tick     out  step enable (combinational from the count register)
module led_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // With DIV=1 CNT_LAST is 0 and the count never leaves 0, so tick is constant 1.
  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine
//   Multi-mode LED pattern generator (bounce, chase, fill bar, blink). Each
//   pattern step is paced by led_tick_gen; a registered strobe marks the start
//   of every pattern period after the first.
// Ports:
//   clk_50M     in   system clock
//   rst         in   asynchronous active-high reset
//   en          in   enable; low blanks the LEDs and clears pattern state
//   mode        in   0 bounce, 1 chase, 2 fill, 3 blink
//   leds        out  registered LED drive, bit 0 = first LED
//   cycle_done  out  one-cycle strobe on the first step of a repeated period
module led_pattern_engine
  import led_effect_pkg::*;
#(
  parameter int N_LEDS = 7,
  parameter int DIV    = 1
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  output logic [N_LEDS-1:0] leds,
  output logic              cycle_done
);

  localparam int POS_W = $clog2(N_LEDS + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_FULL = POS_W'(N_LEDS);

  mode_t             mode_q, mode_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  dir_e              dir_q, dir_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              cycle_done_q, cycle_done_d;
  // Set once the first step of the current run has been shown; a later step
  // back at pos 0 therefore closes a full period.
  logic              started_q, started_d;

  logic tick;
  logic mode_change;
  logic tick_clr;

  assign mode_change = (mode != mode_q);
  assign tick_clr    = !en || mode_change;

  led_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk_50M (clk_50M),
    .rst     (rst),
    .clr     (tick_clr),
    .tick    (tick)
  );

  function automatic logic [N_LEDS-1:0] pattern(input mode_t m, input logic [POS_W-1:0] p);
    logic [N_LEDS-1:0] r;
    r = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      case (m)
        MODE_BOUNCE, MODE_CHASE: r[i] = (p == POS_W'(i));
        MODE_FILL:               r[i] = (POS_W'(i) < p);
        default:                 r[i] = (p == '0);
      endcase
    end
    return r;
  endfunction

  always_comb begin
    mode_d       = mode_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    leds_d       = leds_q;
    started_d    = started_q;
    cycle_done_d = 1'b0;

    if (!en) begin
      mode_d    = mode;
      pos_d     = '0;
      dir_d     = DIR_UP;
      leds_d    = '0;
      started_d = 1'b0;
    end else if (mode_change) begin
      // Mode change wins over a coincident tick; leds keep their value.
      mode_d    = mode;
      pos_d     = '0;
      dir_d     = DIR_UP;
      started_d = 1'b0;
    end else if (tick) begin
      leds_d       = pattern(mode_q, pos_q);
      cycle_done_d = started_q && (pos_q == '0);
      started_d    = 1'b1;
      case (mode_q)
        MODE_BOUNCE: begin
          // Turn around at both ends without repeating the end position.
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              pos_d = POS_LAST - 1'b1;
              dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = POS_W'(1);
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        MODE_CHASE: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        MODE_FILL:  pos_d = (pos_q == POS_FULL) ? '0 : pos_q + 1'b1;
        default:    pos_d = (pos_q == '0) ? POS_W'(1) : '0;
      endcase
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_BOUNCE;
      pos_q        <= '0;
      dir_q        <= DIR_UP;
      leds_q       <= '0;
      cycle_done_q <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      leds_q       <= leds_d;
      cycle_done_q <= cycle_done_d;
      started_q    <= started_d;
    end
  end

  assign leds       = leds_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT a: N_LEDS=7, DIV=1
  logic       rst_a = 1'b0, en_a = 1'b0, cd_a;
  logic [1:0] mode_a = 2'd0;
  logic [6:0] leds_a;
  // DUT b: N_LEDS=7, DIV=4
  logic       rst_b = 1'b0, en_b = 1'b0, cd_b;
  logic [1:0] mode_b = 2'd0;
  logic [6:0] leds_b;
  // DUT c: N_LEDS=2, DIV=1
  logic       rst_c = 1'b0, en_c = 1'b0, cd_c;
  logic [1:0] mode_c = 2'd0;
  logic [1:0] leds_c;

  led_pattern_engine #(.N_LEDS(7), .DIV(1)) dut_a (
    .clk_50M(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .leds(leds_a), .cycle_done(cd_a));
  led_pattern_engine #(.N_LEDS(7), .DIV(4)) dut_b (
    .clk_50M(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .leds(leds_b), .cycle_done(cd_b));
  led_pattern_engine #(.N_LEDS(2), .DIV(1)) dut_c (
    .clk_50M(clk), .rst(rst_c), .en(en_c), .mode(mode_c), .leds(leds_c), .cycle_done(cd_c));

  task automatic edge_wait;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    total++; if (leds_a !== 7'h00 || cd_a !== 1'b0) begin bad++; $display("FAIL reset_a: leds=%h cd=%b want leds=00 cd=0", leds_a, cd_a); end
    total++; if (leds_b !== 7'h00 || cd_b !== 1'b0) begin bad++; $display("FAIL reset_b: leds=%h cd=%b want leds=00 cd=0", leds_b, cd_b); end
    total++; if (leds_c !== 2'h0 || cd_c !== 1'b0) begin bad++; $display("FAIL reset_c: leds=%h cd=%b want leds=0 cd=0", leds_c, cd_c); end
    $display("reset: leds_a=%h leds_b=%h leds_c=%h", leds_a, leds_b, leds_c);
  endtask

  task automatic test_bounce;
    logic [6:0] exp_l [0:13];
    exp_l = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40,
              7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01, 7'h02};
    en_a = 1'b1; mode_a = 2'd0;
    @(negedge clk); rst_a = 1'b0;
    for (int i = 0; i < 14; i++) begin
      edge_wait();
      total++;
      if (leds_a !== exp_l[i] || cd_a !== (i == 12)) begin
        bad++; $display("FAIL bounce[%0d]: leds=%h cd=%b want leds=%h cd=%b", i, leds_a, cd_a, exp_l[i], (i == 12));
      end
      $display("bounce[%0d]: leds=%h cd=%b", i, leds_a, cd_a);
    end
  endtask

  task automatic test_chase;
    logic [6:0] exp_l [0:7];
    exp_l = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h01};
    mode_a = 2'd1;
    edge_wait();
    total++;
    if (leds_a !== 7'h02 || cd_a !== 1'b0) begin bad++; $display("FAIL chase_hold: leds=%h cd=%b want leds=02 cd=0", leds_a, cd_a); end
    for (int i = 0; i < 8; i++) begin
      edge_wait();
      total++;
      if (leds_a !== exp_l[i] || cd_a !== (i == 7)) begin
        bad++; $display("FAIL chase[%0d]: leds=%h cd=%b want leds=%h cd=%b", i, leds_a, cd_a, exp_l[i], (i == 7));
      end
      $display("chase[%0d]: leds=%h cd=%b", i, leds_a, cd_a);
    end
  endtask

  task automatic test_mode_switch;
    logic [6:0] pre_l [0:2];
    logic [6:0] exp_l [0:8];
    pre_l = '{7'h02, 7'h04, 7'h08};
    exp_l = '{7'h00, 7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F, 7'h00};
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      total++;
      if (leds_a !== pre_l[i] || cd_a !== 1'b0) begin
        bad++; $display("FAIL chase_pre[%0d]: leds=%h cd=%b want leds=%h cd=0", i, leds_a, cd_a, pre_l[i]);
      end
    end
    mode_a = 2'd2;
    edge_wait();
    total++;
    if (leds_a !== 7'h08 || cd_a !== 1'b0) begin bad++; $display("FAIL switch_hold: leds=%h cd=%b want leds=08 cd=0", leds_a, cd_a); end
    for (int i = 0; i < 9; i++) begin
      edge_wait();
      total++;
      if (leds_a !== exp_l[i] || cd_a !== (i == 8)) begin
        bad++; $display("FAIL fill[%0d]: leds=%h cd=%b want leds=%h cd=%b", i, leds_a, cd_a, exp_l[i], (i == 8));
      end
      $display("fill[%0d]: leds=%h cd=%b", i, leds_a, cd_a);
    end
  endtask

  task automatic test_en_off;
    logic [6:0] b_l [0:2];
    logic [6:0] f_l [0:2];
    b_l = '{7'h01, 7'h02, 7'h04};
    f_l = '{7'h00, 7'h01, 7'h03};
    mode_a = 2'd0;
    edge_wait();
    total++;
    if (leds_a !== 7'h00 || cd_a !== 1'b0) begin bad++; $display("FAIL en_hold: leds=%h cd=%b want leds=00 cd=0", leds_a, cd_a); end
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      total++;
      if (leds_a !== b_l[i]) begin bad++; $display("FAIL en_pre[%0d]: leds=%h want %h", i, leds_a, b_l[i]); end
    end
    en_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edge_wait();
      total++;
      if (leds_a !== 7'h00 || cd_a !== 1'b0) begin bad++; $display("FAIL en_off[%0d]: leds=%h cd=%b want leds=00 cd=0", i, leds_a, cd_a); end
      $display("en_off[%0d]: leds=%h", i, leds_a);
    end
    en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      total++;
      if (leds_a !== b_l[i] || cd_a !== 1'b0) begin bad++; $display("FAIL en_restart[%0d]: leds=%h cd=%b want leds=%h cd=0", i, leds_a, cd_a, b_l[i]); end
      $display("en_restart[%0d]: leds=%h", i, leds_a);
    end
    // Mode changed while disabled: tracked without a hold cycle on en rise.
    en_a = 1'b0;
    edge_wait();
    mode_a = 2'd2;
    edge_wait();
    en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      total++;
      if (leds_a !== f_l[i] || cd_a !== 1'b0) begin bad++; $display("FAIL en_mode[%0d]: leds=%h cd=%b want leds=%h cd=0", i, leds_a, cd_a, f_l[i]); end
      $display("en_mode[%0d]: leds=%h", i, leds_a);
    end
  endtask

  task automatic test_async_reset;
    logic [6:0] exp_l [0:5];
    logic [6:0] post_l [0:3];
    exp_l  = '{7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F, 7'h00};
    post_l = '{7'h00, 7'h00, 7'h01, 7'h03};
    for (int i = 0; i < 6; i++) begin
      edge_wait();
      total++;
      if (leds_a !== exp_l[i] || cd_a !== (i == 5)) begin
        bad++; $display("FAIL arst_pre[%0d]: leds=%h cd=%b want leds=%h cd=%b", i, leds_a, cd_a, exp_l[i], (i == 5));
      end
    end
    #2 rst_a = 1'b1;
    #1;
    total++;
    if (leds_a !== 7'h00 || cd_a !== 1'b0) begin bad++; $display("FAIL arst_now: leds=%h cd=%b want leds=00 cd=0", leds_a, cd_a); end
    $display("arst: leds=%h cd=%b", leds_a, cd_a);
    @(negedge clk); rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge_wait();
      total++;
      if (leds_a !== post_l[i] || cd_a !== 1'b0) begin
        bad++; $display("FAIL arst_post[%0d]: leds=%h cd=%b want leds=%h cd=0", i, leds_a, cd_a, post_l[i]);
      end
      $display("arst_post[%0d]: leds=%h", i, leds_a);
    end
  endtask

  task automatic test_blink_div4;
    logic [6:0] exp_l [0:19];
    exp_l = '{7'h00, 7'h00, 7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00,
              7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h7F};
    en_b = 1'b1; mode_b = 2'd3;
    @(negedge clk); rst_b = 1'b0;
    // First edge is the mode change (reset leaves bounce selected).
    edge_wait();
    total++;
    if (leds_b !== 7'h00 || cd_b !== 1'b0) begin bad++; $display("FAIL blink_hold: leds=%h cd=%b want leds=00 cd=0", leds_b, cd_b); end
    for (int i = 0; i < 20; i++) begin
      edge_wait();
      total++;
      if (leds_b !== exp_l[i] || cd_b !== (i == 11 || i == 19)) begin
        bad++; $display("FAIL blink[%0d]: leds=%h cd=%b want leds=%h cd=%b", i, leds_b, cd_b, exp_l[i], (i == 11 || i == 19));
      end
      $display("blink[%0d]: leds=%h cd=%b", i, leds_b, cd_b);
    end
  endtask

  task automatic test_n2_bounce;
    logic [1:0] exp_l [0:5];
    exp_l = '{2'h1, 2'h2, 2'h1, 2'h2, 2'h1, 2'h2};
    en_c = 1'b1; mode_c = 2'd0;
    @(negedge clk); rst_c = 1'b0;
    for (int i = 0; i < 6; i++) begin
      edge_wait();
      total++;
      if (leds_c !== exp_l[i] || cd_c !== (i == 2 || i == 4)) begin
        bad++; $display("FAIL n2[%0d]: leds=%h cd=%b want leds=%h cd=%b", i, leds_c, cd_c, exp_l[i], (i == 2 || i == 4));
      end
      $display("n2[%0d]: leds=%h cd=%b", i, leds_c, cd_c);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_chase();
    test_mode_switch();
    test_en_off();
    test_async_reset();
    test_blink_div4();
    test_n2_bounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
